// File: rtl/pixie_line_fetch_if.sv
// Port-B bus between the Pixie line fetcher (master) and the shared dual-port RAM (slave).
interface pixie_line_fetch_if #(parameter int ADDR_WIDTH = 14);
  logic                  ram_cs_b;
  logic                  ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_ad_b;
  logic [7:0]            ram_d_b;
  logic                  b_ack;
  logic [7:0]            ram_q_b;

  modport master (output ram_cs_b, ram_we_b, ram_ad_b, ram_d_b,
                  input  b_ack, ram_q_b);
  modport slave  (input  ram_cs_b, ram_we_b, ram_ad_b, ram_d_b,
                  output b_ack, ram_q_b);
endinterface

// File: rtl/pixie_line_fetch.sv
// CDP1861 display-line fetcher: 8-byte RAM fetch into a back buffer, swap on line_start, 64-pixel MSB-first shifter.
// Optional PIXIE_FETCH_STATS_EN adds a saturating underrun_cnt output.
module pixie_line_fetch #(
  parameter int ADDR_WIDTH      = 14,
  parameter int LINES_PER_FRAME = 32
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  line_req,
  input  logic                  line_start,
  input  logic                  pix_ce,
  pixie_line_fetch_if.master    ram,
  output logic                  pixel,
  output logic                  pix_valid,
  output logic                  line_ready,
  output logic                  busy,
  output logic                  underrun
`ifdef PIXIE_FETCH_STATS_EN
  ,
  output logic [7:0]            underrun_cnt
`endif
);

  localparam int LCW = $clog2(LINES_PER_FRAME + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]            state;
  logic [2:0]            byte_idx;
  logic [LCW-1:0]        line_cnt;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] ad_q;
  logic                  cs_q;
  logic [0:7][7:0]       back;
  logic [63:0]           front;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_nxt;
  logic                  start_ok;
  logic                  start_bad;

  assign start_ok  = line_start &&  line_ready;
  assign start_bad = line_start && !line_ready;
  assign bit_nxt   = bit_cnt + 6'd1;

  assign ram.ram_cs_b = cs_q;
  assign ram.ram_ad_b = ad_q;
  assign ram.ram_we_b = 1'b0;
  assign ram.ram_d_b  = 8'h00;

  // Fetch FSM; frame_start overrides everything, including a same-cycle ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_idx   <= '0;
      line_cnt   <= '0;
      line_addr  <= '0;
      ad_q       <= '0;
      cs_q       <= 1'b0;
      busy       <= 1'b0;
      line_ready <= 1'b0;
      underrun   <= 1'b0;
      back       <= '0;
    end else begin
      cs_q <= 1'b0;
      if (start_ok)  line_ready <= 1'b0;
      if (start_bad) underrun   <= 1'b1;
      if (frame_start) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        byte_idx   <= '0;
        line_cnt   <= '0;
        line_addr  <= base_addr;
        line_ready <= 1'b0;
        underrun   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (line_req && !line_ready && line_cnt < LCW'(LINES_PER_FRAME)) begin
              state <= S_REQ;
              busy  <= 1'b1;
              cs_q  <= 1'b1;
              ad_q  <= line_addr + ADDR_WIDTH'(byte_idx);
            end
          end
          S_REQ: state <= S_WAIT;
          S_WAIT: begin
            if (ram.b_ack) begin
              back[byte_idx] <= ram.ram_q_b;
              if (byte_idx == 3'd7) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                byte_idx   <= '0;
                line_ready <= 1'b1;
                line_cnt   <= line_cnt + LCW'(1);
                line_addr  <= line_addr + ADDR_WIDTH'(8);
              end else begin
                state    <= S_REQ;
                byte_idx <= byte_idx + 3'd1;
                cs_q     <= 1'b1;
                ad_q     <= line_addr + ADDR_WIDTH'(byte_idx + 3'd1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // front[63] is byte 0 bit 7, so the pixel for bit_cnt n lives at front[~n].
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      front     <= '0;
      bit_cnt   <= '0;
      pix_valid <= 1'b0;
      pixel     <= 1'b0;
    end else if (start_ok) begin
      front     <= back;
      bit_cnt   <= '0;
      pix_valid <= 1'b1;
      pixel     <= back[0][7];
    end else if (start_bad) begin
      pix_valid <= 1'b0;
      pixel     <= 1'b0;
    end else if (pix_ce && pix_valid) begin
      if (bit_cnt == 6'd63) begin
        pix_valid <= 1'b0;
        pixel     <= 1'b0;
      end else begin
        bit_cnt <= bit_nxt;
        pixel   <= front[~bit_nxt];
      end
    end
  end

`ifdef PIXIE_FETCH_STATS_EN
  always_ff @(posedge clk_sys) begin
    if (reset || frame_start)
      underrun_cnt <= 8'd0;
    else if (start_bad && underrun_cnt != 8'hFF)
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule
